instruction_sequencer: RTL

Parametrised next-generation fetch/decode/execute controller for the micro_8bits core. It keeps the two-word instruction format: opcode, then an immediate/operand word. It adds:
- ready/ack handshakes on both memory ports, so wait states are supported;
- CALL/RET with a return-address stack of configurable depth;
- a HALT state;
- stack fault detection.

It sits between instruction ROM, data memory and the ALU, and drives the ALU through exec, ir, ibr and mbr.

---
 rtl/instruction_sequencer.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//   Fetch/decode/execute controller for the micro_8bits core. It uses a
//   two-word instruction format: an opcode followed by an immediate/operand
//   word. Both memory ports use a ready/ack handshake, so the memory can insert
//   wait states. The controller has CALL/RET with a return-address stack, a
//   HALT state and sticky stack-fault detection. It drives the ALU through
//   exec, ir, ibr and mbr.
//
//   Optional build macro: SEQ_TRAP_EN
//     defined   : a stack fault sets stack_fault, loads PC with TRAP_VECTOR,
//                 empties the stack and resumes fetching.
//     undefined : a stack fault sets stack_fault and halts.
//                 TRAP_VECTOR has no effect in this build.
//
// Ports:
//   clk          rising-edge clock
//   arst         asynchronous active-high reset
//   inst_addr    program counter (registered)
//   inst_data    instruction word at inst_addr
//   inst_valid   inst_data valid this cycle
//   mem_addr     data memory address / MAR (registered)
//   mem_data_i   data memory read data
//   mem_data_o   data memory write data (registered)
//   mem_we       write strobe, meaningful only while mem_req is high
//   mem_req      memory access request
//   mem_ack      access complete; ignored while mem_req is low
//   exec         one-cycle ALU execute pulse
//   flags        ALU flags, indexed by `ZERO / `CARRY / `NEG / `OV
//   ar           accumulator
//   ir           instruction register
//   ibr          immediate buffer register
//   mbr          memory read buffer
//   halted       sequencer stopped (left only by arst)
//   stack_fault  sticky stack overflow/underflow indicator
// -----------------------------------------------------------------------------

`ifndef ZERO
`define ZERO 0
`endif
`ifndef CARRY
`define CARRY 1
`endif
`ifndef NEG
`define NEG 2
`endif
`ifndef OV
`define OV 3
`endif

module instruction_sequencer #(
    parameter int unsigned INST_ADDR_WIDTH = 8,
    parameter int unsigned INST_DATA_WIDTH = 8,
    parameter int unsigned MEM_ADDR_WIDTH  = 8,
    parameter int unsigned MEM_DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH     = 4,
    parameter int unsigned TRAP_VECTOR     = 0
) (
    input  logic                       clk,
    input  logic                       arst,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr,
    input  logic [INST_DATA_WIDTH-1:0] inst_data,
    input  logic                       inst_valid,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_data_i,
    output logic [MEM_DATA_WIDTH-1:0]  mem_data_o,
    output logic                       mem_we,
    output logic                       mem_req,
    input  logic                       mem_ack,
    output logic                       exec,
    input  logic [3:0]                 flags,
    input  logic [MEM_DATA_WIDTH-1:0]  ar,
    output logic [INST_DATA_WIDTH-1:0] ir,
    output logic [INST_DATA_WIDTH-1:0] ibr,
    output logic [MEM_DATA_WIDTH-1:0]  mbr,
    output logic                       halted,
    output logic                       stack_fault
);

    localparam int unsigned IAW = INST_ADDR_WIDTH;
    localparam int unsigned MAW = MEM_ADDR_WIDTH;
    localparam int unsigned MDW = MEM_DATA_WIDTH;

    // Stack pointer counts entries (0..STACK_DEPTH). The storage index is
    // rounded up to a power of two so index and pointer widths line up.
    localparam int unsigned SPW         = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDXW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned STACK_SLOTS = 1 << IDXW;

    localparam logic [IAW-1:0] TRAP_PC = IAW'(TRAP_VECTOR);

`ifdef SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Opcode map (8-bit view of the instruction register)
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_LOAD_X  = 8'h01;
    localparam logic [7:0] OP_STORE_X = 8'h02;
    localparam logic [7:0] OP_STORE_I = 8'h03;
    localparam logic [7:0] OP_JMP     = 8'h10;
    localparam logic [7:0] OP_JZ      = 8'h11;
    localparam logic [7:0] OP_JC      = 8'h12;
    localparam logic [7:0] OP_JN      = 8'h13;
    localparam logic [7:0] OP_JV      = 8'h14;
    localparam logic [7:0] OP_CALL    = 8'h20;
    localparam logic [7:0] OP_RET     = 8'h21;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ_MEM,
        S_WRITE_MEM,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t           state;
    logic [IAW-1:0]   pc;
    logic [MAW-1:0]   mar;
    logic [SPW-1:0]   sp;
    logic [IAW-1:0]   stack_mem [STACK_SLOTS];

    logic [7:0]       op_c;
    logic             is_store_x_c;
    logic             is_store_i_c;
    logic             is_read_c;
    logic             is_halt_c;
    logic             take_c;
    logic             push_c;
    logic             pop_c;
    logic             overflow_c;
    logic             underflow_c;
    logic [IAW-1:0]   pc_rel_c;

    assign inst_addr = pc;
    assign mem_addr  = mar;

    // Opcode classification used in DECODE
    assign op_c         = 8'(ir);
    assign is_store_x_c = (op_c == OP_STORE_X);
    assign is_store_i_c = (op_c == OP_STORE_I);
    assign is_read_c    = (op_c == OP_LOAD_X) ||
                          (op_c[7:2] == 6'b010000) ||
                          (op_c[7:2] == 6'b100000);
    assign is_halt_c    = (op_c == OP_HALT);

    // Control-flow decision used in EXECUTE
    always_comb begin
        take_c = 1'b0;
        push_c = 1'b0;
        pop_c  = 1'b0;
        case (op_c)
            OP_JMP:  take_c = 1'b1;
            OP_JZ:   take_c = flags[`ZERO];
            OP_JC:   take_c = flags[`CARRY];
            OP_JN:   take_c = flags[`NEG];
            OP_JV:   take_c = flags[`OV];
            OP_CALL: push_c = 1'b1;
            OP_RET:  pop_c  = 1'b1;
            OP_NOP:  take_c = 1'b0;
            default: take_c = 1'b0;
        endcase
    end

    assign overflow_c  = push_c && (sp == SPW'(STACK_DEPTH));
    assign underflow_c = pop_c && (sp == '0);

    // PC is already past the operand here; relative target wraps naturally
    assign pc_rel_c = pc + IAW'(ibr);

    // Sequencer state machine and all registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_FETCH;
            pc          <= '0;
            mar         <= '0;
            mem_data_o  <= '0;
            mem_we      <= 1'b0;
            mem_req     <= 1'b0;
            exec        <= 1'b0;
            ir          <= '0;
            ibr         <= '0;
            mbr         <= '0;
            halted      <= 1'b0;
            stack_fault <= 1'b0;
            sp          <= '0;
            for (int i = 0; i < STACK_SLOTS; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            exec <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (inst_valid) begin
                        ir    <= inst_data;
                        pc    <= pc + IAW'(1);
                        state <= S_DECODE;
                    end
                end

                // Memory request is raised on the transition so it is
                // already high in the first cycle of the access state.
                S_DECODE: begin
                    if (inst_valid) begin
                        ibr <= inst_data;
                        pc  <= pc + IAW'(1);
                        if (is_store_x_c) begin
                            mar        <= MAW'(inst_data);
                            mem_data_o <= ar;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b1;
                            state      <= S_WRITE_MEM;
                        end else if (is_store_i_c) begin
                            mar        <= MAW'(ar);
                            mem_data_o <= MDW'(inst_data);
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b1;
                            state      <= S_WRITE_MEM;
                        end else if (is_read_c) begin
                            mar     <= MAW'(inst_data);
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state   <= S_READ_MEM;
                        end else if (is_halt_c) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            exec  <= 1'b1;
                            state <= S_EXECUTE;
                        end
                    end
                end

                S_READ_MEM: begin
                    if (mem_ack) begin
                        mbr     <= mem_data_i;
                        mem_req <= 1'b0;
                        exec    <= 1'b1;
                        state   <= S_EXECUTE;
                    end
                end

                S_WRITE_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        exec    <= 1'b1;
                        state   <= S_EXECUTE;
                    end
                end

                // Stack faults leave PC and stack untouched unless trapping
                S_EXECUTE: begin
                    state <= S_FETCH;
                    if (overflow_c || underflow_c) begin
                        stack_fault <= 1'b1;
                        if (TRAP_EN) begin
                            pc <= TRAP_PC;
                            sp <= '0;
                        end else begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                    end else if (push_c) begin
                        stack_mem[IDXW'(sp)] <= pc;
                        sp                   <= sp + SPW'(1);
                        pc                   <= pc_rel_c;
                    end else if (pop_c) begin
                        pc <= stack_mem[IDXW'(sp - SPW'(1))];
                        sp <= sp - SPW'(1);
                    end else if (take_c) begin
                        pc <= pc_rel_c;
                    end
                end

                S_HALT: begin
                    halted <= 1'b1;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
